// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential comparator:
//     - FSM state encoding (IDLE / RUN / DONE)
//     - bit positions of the always-present flags inside the packed flag vector
//     - clog2 helper used to size the slice counter at elaboration
//   No ports; imported with "import alu_pkg::*;".
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Packed flag vector layout. The overflow flag is kept outside this
  // vector because it only exists when the overflow feature is built in.
  localparam int FLAG_EQ   = 0;
  localparam int FLAG_NE   = 1;
  localparam int FLAG_GT   = 2;
  localparam int FLAG_LT   = 3;
  localparam int FLAG_UGT  = 4;
  localparam int FLAG_ULT  = 5;
  localparam int NUM_FLAGS = 6;

  // Ceiling log2; clog2(1) = 0, callers clamp to a minimum width of 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// -----------------------------------------------------------------------------
// chunk_subtractor
//   One CHUNK-bit slice of a ripple subtract-with-borrow chain.
//   Purely combinational.
// Ports:
//   a_slice     in   CHUNK  minuend slice
//   b_slice     in   CHUNK  subtrahend slice
//   borrow_in   in   1      borrow from the next-lower slice
//   diff        out  CHUNK  a_slice - b_slice - borrow_in (mod 2^CHUNK)
//   borrow_out  out  1      borrow into the next-higher slice
//   slice_equal out  1      a_slice == b_slice (independent of borrow)
// -----------------------------------------------------------------------------
module chunk_subtractor #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_slice,
  input  logic [CHUNK-1:0] b_slice,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] diff,
  output logic             borrow_out,
  output logic             slice_equal
);

  // One extra bit catches the borrow: the result range is
  // [-2^CHUNK, 2^CHUNK-1], so the top bit is set exactly when it went negative.
  logic [CHUNK:0] full;

  assign full        = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_in};
  assign diff        = full[CHUNK-1:0];
  assign borrow_out  = full[CHUNK];
  assign slice_equal = (a_slice == b_slice);

endmodule

// File: rtl/seq_comparator.sv
// -----------------------------------------------------------------------------
// seq_comparator
//   Multi-cycle signed/unsigned comparator (branch resolution, slt/sltu).
//   Operands are latched on accept and processed CHUNK bits per cycle, LSB
//   first, through a subtract-with-borrow chain. After NUM_CHUNKS cycles all
//   flags are registered and presented with out_valid until the consumer
//   takes them. A new operand pair may be accepted in the same cycle the
//   previous result is consumed.
//
// Build option:
//   SEQ_COMPARATOR_OVERFLOW_EN  when defined, flag_overflow reports signed
//                               overflow of a-b (registered with the other
//                               flags). When undefined, flag_overflow is tied
//                               to 0 and no overflow register is built.
//
// Parameters:
//   WORDSIZE  operand width (must be a multiple of CHUNK)
//   CHUNK     bits processed per cycle
//
// Ports:
//   clk            in   1         clock, rising edge
//   rst_n          in   1         asynchronous active-low reset
//   in_valid       in   1         operands valid
//   in_ready       out  1         block can accept operands
//   input_a        in   WORDSIZE  first operand
//   input_b        in   WORDSIZE  second operand
//   out_valid      out  1         flags valid
//   out_ready      in   1         consumer accepts flags
//   flag_equal     out  1         a == b
//   flag_not_equal out  1         a != b
//   flag_greater   out  1         a > b, signed
//   flag_less      out  1         a < b, signed
//   flag_u_greater out  1         a > b, unsigned
//   flag_u_less    out  1         a < b, unsigned
//   flag_overflow  out  1         signed overflow of a-b (0 unless enabled)
// -----------------------------------------------------------------------------
module seq_comparator
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int CHUNK    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                flag_equal,
  output logic                flag_not_equal,
  output logic                flag_greater,
  output logic                flag_less,
  output logic                flag_u_greater,
  output logic                flag_u_less,
  output logic                flag_overflow
);

  localparam int NUM_CHUNKS = WORDSIZE / CHUNK;
  localparam int CNT_W      = (clog2(NUM_CHUNKS) > 1) ? clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  generate
    if ((CHUNK < 1) || (WORDSIZE < CHUNK) || ((WORDSIZE % CHUNK) != 0)) begin : g_bad_cfg
      $error("seq_comparator: WORDSIZE must be a positive multiple of CHUNK");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic                   borrow_q;
  logic                   zero_q;
  logic                   out_valid_q;
  logic [NUM_FLAGS-1:0]   flags_q;

  // Operand shift registers: the slice being processed is always the low
  // CHUNK bits, so the final slice naturally carries the operand sign bits.
  logic [WORDSIZE-1:0]    a_q;
  logic [WORDSIZE-1:0]    b_q;

  // ---------------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0]       a_slice;
  logic [CHUNK-1:0]       b_slice;
  logic [CHUNK-1:0]       diff;
  logic                   borrow_out;
  logic                   slice_equal;

  logic                   accept;
  logic                   finish;
  logic                   a_msb;
  logic                   b_msb;
  logic                   diff_msb;
  logic                   ovf;
  logic                   eq_d;
  logic                   less_d;
  logic                   u_less_d;
  logic [NUM_FLAGS-1:0]   flags_d;
  logic [WORDSIZE-1:0]    a_shift_d;
  logic [WORDSIZE-1:0]    b_shift_d;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign finish   = (state_q == ST_RUN) && (count_q == LAST_CNT);

  assign a_slice  = a_q[CHUNK-1:0];
  assign b_slice  = b_q[CHUNK-1:0];

  chunk_subtractor #(
    .CHUNK (CHUNK)
  ) u_chunk_subtractor (
    .a_slice     (a_slice),
    .b_slice     (b_slice),
    .borrow_in   (borrow_q),
    .diff        (diff),
    .borrow_out  (borrow_out),
    .slice_equal (slice_equal)
  );

  // Final-slice flag derivation. These values are only captured on the
  // finishing edge, when the slice holds the operands' top bits.
  assign a_msb    = a_slice[CHUNK-1];
  assign b_msb    = b_slice[CHUNK-1];
  assign diff_msb = diff[CHUNK-1];

  always_comb begin
    eq_d     = zero_q & slice_equal;
    u_less_d = borrow_out;
    // Signed overflow of a-b: operands of different sign and the result sign
    // disagrees with a. The signed ordering is the result sign corrected by it.
    ovf      = (a_msb != b_msb) & (diff_msb != a_msb);
    less_d   = diff_msb ^ ovf;

    flags_d            = '0;
    flags_d[FLAG_EQ]   = eq_d;
    flags_d[FLAG_NE]   = ~eq_d;
    flags_d[FLAG_LT]   = less_d;
    flags_d[FLAG_GT]   = ~less_d & ~eq_d;
    flags_d[FLAG_ULT]  = u_less_d;
    flags_d[FLAG_UGT]  = ~u_less_d & ~eq_d;
  end

  assign a_shift_d = a_q >> CHUNK;
  assign b_shift_d = b_q >> CHUNK;

  // Operand registers carry data only; their content is meaningless outside
  // RUN, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= input_a;
      b_q <= input_b;
    end else if (state_q == ST_RUN) begin
      a_q <= a_shift_d;
      b_q <= b_shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
          end
        end

        ST_RUN: begin
          if (count_q == LAST_CNT) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            flags_q     <= flags_d;
          end else begin
            count_q  <= count_q + CNT_W'(1);
            borrow_q <= borrow_out;
            zero_q   <= zero_q & slice_equal;
          end
        end

        ST_DONE: begin
          // Flags stay put until the consumer takes them; a waiting producer
          // is accepted on the same edge so no bubble cycle is spent in IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q  <= ST_RUN;
              count_q  <= '0;
              borrow_q <= 1'b0;
              zero_q   <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_COMPARATOR_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (finish) begin
      ovf_q <= ovf;
    end
  end

  assign flag_overflow = ovf_q;
`else
  assign flag_overflow = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid      = out_valid_q;
  assign flag_equal     = flags_q[FLAG_EQ];
  assign flag_not_equal = flags_q[FLAG_NE];
  assign flag_greater   = flags_q[FLAG_GT];
  assign flag_less      = flags_q[FLAG_LT];
  assign flag_u_greater = flags_q[FLAG_UGT];
  assign flag_u_less    = flags_q[FLAG_ULT];

endmodule

// File: tb/tb_seq_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_comparator
//   Self-checking bench for seq_comparator (WORDSIZE=64, CHUNK=16).
//   A monitor samples on the falling edge, builds expected flags from plain
//   signed/unsigned comparisons of each accepted operand pair, and checks the
//   DUT result, result latency and in_ready behaviour. Directed vectors pin
//   the reference model with hand-computed flag constants.
//   Flag vector order: {eq, ne, gt, lt, ugt, ult, ovf}.
// -----------------------------------------------------------------------------
module tb_seq_comparator;

`ifdef SEQ_COMPARATOR_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] input_a = '0;
  logic [63:0] input_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        flag_equal, flag_not_equal, flag_greater, flag_less;
  logic        flag_u_greater, flag_u_less, flag_overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [6:0] exp_q[$];
  int         acc_cyc = 0;
  bit         prev_ov = 1'b0;

  seq_comparator #(
    .WORDSIZE (64),
    .CHUNK    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input_a        (input_a),
    .input_b        (input_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .flag_equal     (flag_equal),
    .flag_not_equal (flag_not_equal),
    .flag_greater   (flag_greater),
    .flag_less      (flag_less),
    .flag_u_greater (flag_u_greater),
    .flag_u_less    (flag_u_less),
    .flag_overflow  (flag_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] dut_flags();
    return {flag_equal, flag_not_equal, flag_greater, flag_less,
            flag_u_greater, flag_u_less, flag_overflow};
  endfunction

  // Reference: straight from the comparison definitions.
  function automatic logic [6:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic eq, gt, lt, ugt, ult, ov;
    eq  = (a == b);
    gt  = ($signed(a) > $signed(b));
    lt  = ($signed(a) < $signed(b));
    ugt = (a > b);
    ult = (a < b);
    d   = a - b;
    ov  = (a[63] != b[63]) && (d[63] != a[63]);
    return {eq, !eq, gt, lt, ugt, ult, (OVF_ON ? ov : 1'b0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor / compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov)
        chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("flags", 64'(dut_flags()), 64'(exp_q[0]));
          if (!out_ready) chk("in_ready_while_held", 64'(in_ready), 64'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() == 0) begin
        chk("in_ready_idle", 64'(in_ready), 64'd1);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(input_a, input_b));
        acc_cyc = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  // Present one operand pair and hold it until accepted; returns just after
  // the accept edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    @(posedge clk);
    #1;
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic directed(input string name, input logic [63:0] a,
                          input logic [63:0] b, input logic [6:0] lit);
    chk(name, 64'(model(a, b)), 64'(lit));
    send(a, b);
    drain();
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [6:0]  f;
  } vec_t;

  initial begin
    vec_t vt[4];
    logic [6:0] hold;

    // Reset state (asynchronous: checked before any clock edge).
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flags",     64'(dut_flags()), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tests 1-4.
    directed("t1_equal",    64'd5, 64'd5, 7'b1000000);
    directed("t2_m1_vs_1",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 7'b0101100);
    directed("t3_min_vs_1", 64'h8000_0000_0000_0000, 64'd1, {6'b010110, OVF_ON});
    directed("t4_borrow",   64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 7'b0110100);

    // Further directed vectors.
    vt[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, {6'b011001, OVF_ON}};
    vt[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 7'b1000000};
    vt[2] = '{64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 7'b0110100};
    vt[3] = '{64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0001, 7'b0101010};
    foreach (vt[i]) directed($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].f);

    // Test 5: hold result, then back-to-back accept.
    chk("t5a_model", 64'(model(64'hFFFF_FFFF_FFFF_FFFB, 64'd3)), 64'(7'b0101100));
    chk("t5b_model", 64'(model(64'd3, 64'hFFFF_FFFF_FFFF_FFFB)), 64'(7'b0110010));
    out_ready = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFB, 64'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("t5_out_valid", 64'(out_valid), 64'd1);
    hold = dut_flags();
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_flags", 64'(dut_flags()), 64'(hold));
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    input_a   = 64'd3;
    input_b   = 64'hFFFF_FFFF_FFFF_FFFB;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("t5_b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Test 6: reset in RUN at count=2.
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_flags",     64'(dut_flags()), 64'd0);
    chk("t6_rst_in_ready",  64'(in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_no_stale", 64'(out_valid), 64'd0);

    // Recovery after reset.
    directed("t6_recover", 64'd100, 64'd7, 7'b0110100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
